uart_rx_stream: RTL and testbench
=================================

Name: uart_rx_stream

Overview:
Parametrised UART receiver with a built-in receive FIFO and a valid/ready output stream. It replaces the fixed 8N1, 8x-oversampled, 16-deep receiver-plus-FIFO path. It adds configurable oversampling, data width and FIFO depth, mid-bit sampling, start-glitch rejection, and framing/overrun error reporting. It sits between the board RX pin and command parsers or other byte consumers.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate.
- OVS, 16: oversampling ticks per bit; even, at least 4.
- DATA_BITS, 8: data bits per frame, 5 to 8.
- FIFO_DEPTH, 16: receive FIFO entries; power of 2, at least 2.
- PARITY_ODD, 0: 1 = odd parity, 0 = even. Used only with UART_RX_PARITY_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  asynchronous serial input; idles high.
- m_valid  out  1  FIFO non-empty; m_data is valid.
- m_ready  in  1  consumer accepts m_data this cycle.
- m_data  out  DATA_BITS  FIFO head; first bit received sits at bit 0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently held.
- overrun  out  1  one-clk pulse: a completed byte was dropped because the FIFO was full.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- parity_err  out  1  one-clk pulse: parity mismatch (tied 0 without the macro).

Behaviour:
- Reset (async, active-high), including mid-frame:
  - FSM goes to IDLE; all counters, the shift register and the FIFO are cleared.
  - Outputs go to: m_valid 0, m_data 0, fifo_count 0, overrun 0, frame_err 0, parity_err 0.
  - Both synchroniser flops reset to 1.
- Input sync: rx passes through 2 flops to give rx_s. Everything downstream uses rx_s only.
- Tick divider:
  - DIV = CLK_HZ/(BAUD*OVS), integer division.
  - Free-running; tick is high for 1 clk every DIV clks.
  - Counter width is $clog2(DIV).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. A per-bit tick counter cnt runs 0..OVS-1.
- IDLE: on a tick with rx_s==0, go to START with cnt=0.
- START: counts ticks. At cnt==OVS/2-1:
  - rx_s==0: go to DATA, cnt=0, bit index=0.
  - rx_s==1: glitch; go back to IDLE with no flag.
- DATA:
  - At cnt==OVS-1, sample rx_s into the shift register LSB-first (shift right, insert at MSB of the DATA_BITS register), then reset cnt to 0.
  - After DATA_BITS samples, go to PARITY if the macro is defined, else STOP.
- PARITY (macro only): at cnt==OVS-1, sample the parity bit, then go to STOP.
- STOP: at cnt==OVS-1, sample rx_s.
  - rx_s==1, parity OK (or no parity): request a push, go to IDLE.
  - rx_s==1, parity bad: parity_err pulse, no push, go to IDLE.
  - rx_s==0: frame_err pulse, no push (takes priority over any parity error), go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. This prevents back-to-back false frames while the line is held low.
- Push latency: m_valid and fifo_count update 1 clk after the STOP sample cycle.
- FIFO rules:
  - Pop when m_valid && m_ready. m_valid = !empty.
  - m_data shows the head combinationally and stays stable while m_valid && !m_ready.
  - Push while full with no pop: byte dropped, overrun pulse, contents unchanged.
  - Push while full with a pop in the same cycle: both happen; count unchanged; no overrun.
  - Push while empty: m_valid is 0, so no pop occurs.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_count.
- Error pulses last exactly 1 clk. Error pulses never coincide with a push for the same frame.

Optional Feature:
UART_RX_PARITY_EN.
- Defined:
  - Frame is start, DATA_BITS data, one parity bit, stop.
  - The PARITY state exists.
  - Expected parity = XOR of the data bits, XOR PARITY_ODD.
  - On a mismatch the byte is dropped and parity_err pulses.
- Undefined:
  - No PARITY state and no parity logic.
  - parity_err is tied 0; PARITY_ODD is ignored.

Decomposition:
- Package uart_rx_pkg holds:
  - FSM state encoding as localparams (3 bits).
  - Functions computing DIV and counter widths from CLK_HZ/BAUD/OVS.
- One sub-module, uart_rx_sync_fifo, parametrised by WIDTH and DEPTH:
  - push, pop, wdata, rdata, count, full, empty.
  - Implements the simultaneous push/pop-at-full rule above.
- The FSM, tick divider and synchroniser stay in uart_rx_stream.

Test Plan:
Bench settings: CLK_HZ and BAUD chosen so DIV=4, OVS=16, DATA_BITS=8, FIFO_DEPTH=4.
1. Send 0x55 then 0xA3 (8N1), m_ready=1 -> m_valid pulses twice carrying 0x55 then 0xA3; each appears 1 clk after its stop sample; no error pulses.
2. m_ready=0, send 5 bytes 0x01..0x05 -> fifo_count=4, one overrun pulse on the 5th; then m_ready=1 drains 0x01..0x04 in order and count returns to 0.
3. Full FIFO with m_ready=1 asserted in the same cycle as a push -> count stays 4, no overrun, new byte lands at the tail.
4. Stop bit driven low, rx then held low 3 bit times -> a single frame_err pulse, no push, no new frame accepted until rx returns high; then 0x7E received correctly.
5. Low glitch of 4 ticks on idle line -> FSM returns to IDLE, nothing pushed, no flags. Reset asserted mid-DATA -> all outputs 0; next full frame 0x3C received correctly.
6. With UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity 1 -> accepted. Send 0x07 with parity 0 -> parity_err pulse, byte dropped.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the uart_rx_stream receiver:
//   - FSM state encoding (3 bits) as localparams
//   - calc_div  : system clocks per oversampling tick, CLK_HZ/(BAUD*OVS)
//   - cnt_width : counter width able to hold 0..n-1 (never below 1 bit)
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;
    localparam logic [STATE_W-1:0] ST_BREAK  = 3'd5;

    // Integer division; clamped to 1 so a too-fast baud still yields a
    // legal (every-clock) tick instead of a zero-width counter.
    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        int d;
        d = clk_hz / (baud * ovs);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_sync_fifo
// Single-clock FIFO with show-ahead read (rdata is the head, combinational).
// Parameters: WIDTH data width, DEPTH entries (power of 2, >= 2).
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears storage too)
//   push       write wdata at the tail
//   pop        drop the head (ignored when empty)
//   wdata      write data
//   rdata      current head
//   count      entries held, 0..DEPTH
//   full/empty derived from count
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is ignored and the contents stay unchanged.
// ---------------------------------------------------------------------------
module uart_rx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_stream.sv
// ---------------------------------------------------------------------------
// uart_rx_stream
// UART receiver with oversampled mid-bit sampling, start-glitch rejection,
// break handling and a receive FIFO presented as a valid/ready stream.
// Optional feature macro: UART_RX_PARITY_EN (adds one parity bit per frame).
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-high
//   rx          serial input, idles high (synchronised internally)
//   m_valid     FIFO not empty, m_data holds the head
//   m_ready     consumer takes m_data this cycle
//   m_data      FIFO head, first received bit at bit 0
//   fifo_count  entries currently held
//   overrun     1-clk pulse: completed byte dropped, FIFO full
//   frame_err   1-clk pulse: stop bit sampled low
//   parity_err  1-clk pulse: parity mismatch (constant 0 without the macro)
//
// Stream handshake: a transfer happens on every clock edge where
// m_valid && m_ready; m_data is held stable while m_valid && !m_ready,
// and m_valid never drops without a transfer.
// ---------------------------------------------------------------------------
module uart_rx_stream
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVS        = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_BITS-1:0]          m_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          parity_err
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
    localparam int DW  = cnt_width(DIV);
    localparam int CW  = cnt_width(OVS);
    localparam int BW  = cnt_width(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVS - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(OVS / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    // Elaboration-time parameter sanity checks.
    if ((OVS < 4) || ((OVS % 2) != 0)) begin : g_chk_ovs
        $error("uart_rx_stream: OVS must be even and at least 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_chk_bits
        $error("uart_rx_stream: DATA_BITS must be 5..8");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("uart_rx_stream: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_chk_par
        $error("uart_rx_stream: PARITY_ODD must be 0 or 1");
    end

    // ---------------- input synchroniser (idle-high reset) ----------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ---------------- free-running oversampling tick ----------------
    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- receive FSM ----------------
    logic [STATE_W-1:0]   state;
    logic [STATE_W-1:0]   state_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic [BW-1:0]        bit_idx;
    logic [BW-1:0]        bit_idx_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic                 parity_ok;
    logic                 stop_sample;
    logic                 push;
    logic                 frame_err_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_bit;
    logic par_bit_next;
    logic parity_err_d;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_bit_next;
`endif
        end
    end

    // Next-state logic. cnt counts ticks within the current bit; the start
    // bit is confirmed half a bit in, so every later sample at cnt==OVS-1
    // lands in the middle of its bit.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
`ifdef UART_RX_PARITY_EN
        par_bit_next = par_bit;
`endif
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (tick && !rx_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (cnt == CNT_HALF) begin
                        cnt_next     = '0;
                        bit_idx_next = '0;
                        // Line back high before mid-start: a glitch, drop it silently.
                        state_next   = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_next     = '0;
                        // LSB-first: shift right, newest bit enters at the MSB.
                        shreg_next   = {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx_next = bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_next     = '0;
                        par_bit_next = rx_s;
                        state_next   = ST_STOP;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line is released so a long low level
                // cannot be read as a string of all-zero frames.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign parity_ok = (par_bit == ((^shreg) ^ PAR_ODD));
`else
    assign parity_ok = 1'b1;
`endif

    // Output decode. A low stop bit is a framing error and masks any
    // parity result for that frame.
    always_comb begin
        stop_sample  = (state == ST_STOP) && tick && (cnt == CNT_LAST);
        push         = stop_sample && rx_s && parity_ok;
        frame_err_d  = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err_d = stop_sample && rx_s && !parity_ok;
`endif
    end

    // ---------------- receive FIFO and stream side ----------------
    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;

    uart_rx_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (shreg),
        .rdata (m_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Error pulses are registered so they are glitch-free single-clock
    // strobes aligned with the cycle in which a push would have shown up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= push && fifo_full && !pop;
            frame_err <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_err_d;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_stream
// Directed plus randomised frames for uart_rx_stream with DIV=4, OVS=16,
// DATA_BITS=8, FIFO_DEPTH=4 (64 clocks per bit). Expected bytes and error
// pulse counts come from the frame rules applied to what the bench sends.
// ---------------------------------------------------------------------------
module tb_uart_rx_stream;

    localparam int CLK_HZ     = 64_000_000;
    localparam int BAUD       = 1_000_000;
    localparam int OVS        = 16;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CLKS   = CLK_HZ / BAUD;
    localparam int TICK_CLKS  = CLK_HZ / (BAUD * OVS);
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Clocks from the leading edge of the start bit to the stop bit.
    localparam int STOP_OFS = (1 + DATA_BITS + PAR_BITS) * BIT_CLKS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx = 1'b1;
    logic m_ready = 1'b0;
    logic m_valid;
    logic [DATA_BITS-1:0] m_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic overrun;
    logic frame_err;
    logic parity_err;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_stream #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVS        (OVS),
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    // ---------------- scoreboard state ----------------
    logic [DATA_BITS-1:0] exp_q[$];
    logic [DATA_BITS-1:0] got_q[$];
    int checks = 0;
    int errors = 0;
    int n_ovr = 0;
    int n_fe = 0;
    int n_pe = 0;
    int n_vcyc = 0;
    int last_rise = -1;
    int frame_start = 0;
    logic prev_valid = 1'b0;
    logic rand_ready = 1'b0;

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (m_valid) n_vcyc++;
            if (m_valid && !prev_valid) last_rise = cyc;
            prev_valid = m_valid;
            if (overrun) n_ovr++;
            if (frame_err) n_fe++;
            if (parity_err) n_pe++;
        end
    end

    // ---------------- checkers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Compare every received byte with the expected stream, in order.
    task automatic check_stream(input string tag);
        logic [DATA_BITS-1:0] e;
        logic [DATA_BITS:0] g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? {1'b0, got_q.pop_front()} : {(DATA_BITS+1){1'b1}};
            checks++;
            assert (g === {1'b0, e}) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", tag, g, e);
            end
        end
        chk({tag, "_extra"}, got_q.size(), 0);
        got_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_parity_err"}, parity_err, 0);
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; drives rx for clks cycles.
    task automatic hold(input logic b, input int clks);
        rx = b;
        repeat (clks) begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Start frames on a fixed clock phase so sampling offsets repeat.
    task automatic align();
        while ((cyc % TICK_CLKS) != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_data_bits(input logic [DATA_BITS-1:0] d);
        frame_start = cyc;
        last_rise   = -1;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < DATA_BITS; i++) hold(d[i], BIT_CLKS);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_bit);
        send_data_bits(d);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ 1'(PARITY_ODD), BIT_CLKS);
`endif
        hold(stop_bit, BIT_CLKS);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [DATA_BITS-1:0] d, input logic par);
        send_data_bits(d);
        hold(par, BIT_CLKS);
        hold(1'b1, BIT_CLKS);
    endtask
`endif

    // ---------------- watchdog ----------------
    initial begin
        #900_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int n_fe0;
        int n_ovr0;
        int n_pe0;
        int cal;
        int fstart;
        logic [DATA_BITS-1:0] d;

        // Reset
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b1, 2 * BIT_CLKS);

        // 1: two frames, consumer always ready
        m_ready = 1'b1;
        n_vcyc  = 0;
        align();
        send_frame(8'h55, 1'b1);
        exp_q.push_back(8'h55);
        chk_rng("t1_lat_55", last_rise - frame_start, STOP_OFS + 20, STOP_OFS + 60);
        align();
        send_frame(8'hA3, 1'b1);
        exp_q.push_back(8'hA3);
        chk_rng("t1_lat_a3", last_rise - frame_start, STOP_OFS + 20, STOP_OFS + 60);
        hold(1'b1, BIT_CLKS);
        check_stream("t1_data");
        chk("t1_valid_cycles", n_vcyc, 2);
        chk("t1_frame_err", n_fe, 0);
        chk("t1_overrun", n_ovr, 0);
        chk("t1_parity_err", n_pe, 0);

        // 2: five bytes into a 4-deep FIFO with no consumer
        m_ready = 1'b0;
        n_ovr0  = n_ovr;
        for (int b = 1; b <= 5; b++) begin
            align();
            send_frame(DATA_BITS'(b), 1'b1);
            if (b <= FIFO_DEPTH) exp_q.push_back(DATA_BITS'(b));
        end
        hold(1'b1, BIT_CLKS);
        chk("t2_count_full", fifo_count, FIFO_DEPTH);
        chk("t2_overrun", n_ovr - n_ovr0, 1);
        chk("t2_valid", m_valid, 1);
        chk("t2_head", m_data, 8'h01);
        m_ready = 1'b1;
        hold(1'b1, 16);
        check_stream("t2_drain");
        chk("t2_count_empty", fifo_count, 0);

        // 3: pop in the same cycle as a push into a full FIFO
        m_ready = 1'b0;
        align();
        send_frame(8'h11, 1'b1);
        cal = last_rise - frame_start;
        chk_rng("t3_lat_cal", cal, STOP_OFS + 20, STOP_OFS + 60);
        align(); send_frame(8'h22, 1'b1);
        align(); send_frame(8'h33, 1'b1);
        align(); send_frame(8'h44, 1'b1);
        chk("t3_count_full", fifo_count, FIFO_DEPTH);
        n_ovr0 = n_ovr;
        align();
        fstart = cyc;
        fork
            send_frame(8'h99, 1'b1);
            begin
                wait_until(fstart + cal - 1);
                m_ready = 1'b1;
                @(posedge clk);
                #1 m_ready = 1'b0;
            end
        join
        hold(1'b1, 8);
        chk("t3_count_kept", fifo_count, FIFO_DEPTH);
        chk("t3_no_overrun", n_ovr - n_ovr0, 0);
        exp_q.push_back(8'h11);
        check_stream("t3_popped");
        m_ready = 1'b1;
        hold(1'b1, 16);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h99);
        check_stream("t3_drain");
        chk("t3_count_empty", fifo_count, 0);

        // 4: low stop bit followed by a held-low line
        n_fe0 = n_fe;
        align();
        send_frame(8'h5A, 1'b0);
        hold(1'b0, 3 * BIT_CLKS);
        hold(1'b1, BIT_CLKS);
        chk("t4_frame_err", n_fe - n_fe0, 1);
        check_stream("t4_no_push");
        chk("t4_count", fifo_count, 0);
        align();
        send_frame(8'h7E, 1'b1);
        hold(1'b1, BIT_CLKS);
        exp_q.push_back(8'h7E);
        check_stream("t4_recover");
        chk("t4_frame_err_after", n_fe - n_fe0, 1);

        // 5a: short low glitch on an idle line
        n_fe0 = n_fe; n_ovr0 = n_ovr; n_pe0 = n_pe;
        align();
        hold(1'b0, 4 * TICK_CLKS);
        hold(1'b1, 2 * BIT_CLKS);
        check_stream("t5_glitch");
        chk("t5_glitch_flags", (n_fe - n_fe0) + (n_ovr - n_ovr0) + (n_pe - n_pe0), 0);
        chk("t5_glitch_count", fifo_count, 0);

        // 5b: reset in the middle of the data bits with a byte queued
        m_ready = 1'b0;
        align();
        send_frame(8'hC3, 1'b1);
        hold(1'b1, 8);
        chk("t5_pre_count", fifo_count, 1);
        hold(1'b0, BIT_CLKS);
        hold(1'b1, BIT_CLKS);
        hold(1'b0, BIT_CLKS / 2);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("t5_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b1, BIT_CLKS);
        m_ready = 1'b1;
        align();
        send_frame(8'h3C, 1'b1);
        hold(1'b1, BIT_CLKS);
        exp_q.push_back(8'h3C);
        check_stream("t5_after_rst");

`ifdef UART_RX_PARITY_EN
        // 6: parity accept / reject
        n_pe0 = n_pe;
        align();
        send_frame_par(8'h07, 1'b1);
        hold(1'b1, BIT_CLKS);
        if (1'b1 == ((^8'h07) ^ 1'(PARITY_ODD))) exp_q.push_back(8'h07);
        check_stream("t6_par_good");
        chk("t6_no_parity_err", n_pe - n_pe0, 0);
        align();
        send_frame_par(8'h07, 1'b0);
        hold(1'b1, BIT_CLKS);
        check_stream("t6_par_bad_dropped");
        chk("t6_parity_err", n_pe - n_pe0, 1);
`endif

        // Random bytes with a randomly stalling consumer
        n_fe0 = n_fe; n_ovr0 = n_ovr; n_pe0 = n_pe;
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
            align();
            send_frame(d, 1'b1);
            exp_q.push_back(d);
        end
        rand_ready = 1'b0;
        m_ready = 1'b1;
        hold(1'b1, BIT_CLKS);
        check_stream("rand_data");
        chk("rand_flags", (n_fe - n_fe0) + (n_ovr - n_ovr0) + (n_pe - n_pe0), 0);
        chk("rand_count", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
